calc_result_serializer: RTL

Downstream stage of the combinational arithmetic block (results s1..s6). It captures one 6-word result set per valid/ready transaction into a small FIFO and serializes each set onto a single BW-wide output stream, one word per transfer, tagged with word index and a last flag. It also keeps a running modular checksum and a frame counter for in-system verification.

---
 rtl/calc_result_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/calc_result_serializer.sv
// calc_result_serializer
//   Captures one six-word result set (s1..s6) per in_valid/in_ready transaction
//   into a DEPTH-frame FIFO and streams each frame out one BW-bit word per
//   transfer, tagged with its index and a last flag. A running modular checksum
//   of every transferred word and a count of completed frames are kept for
//   in-system checking.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   frame handshake; in_ready = FIFO not full (registered)
//   s1..s6                result words 0..5 of the offered frame
//   out_valid / out_ready word handshake on the output stream
//   out_data              current word of the head frame
//   out_idx, out_last     word index 0..5, high on index 5
//   checksum              sum mod 2^BW of all transferred words since reset
//   frame_cnt             completed frames since reset (wraps at 2^16)
module calc_result_serializer #(
    parameter int unsigned BW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] s1,
    input  logic [BW-1:0] s2,
    input  logic [BW-1:0] s3,
    input  logic [BW-1:0] s4,
    input  logic [BW-1:0] s5,
    input  logic [BW-1:0] s6,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic [BW-1:0] checksum,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam logic [2:0]  LastIdx = 3'd5;

    typedef enum logic {StIdle, StSend} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      idx_q, idx_d;
    logic            ready_q;
    logic [BW-1:0]   checksum_q, checksum_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]   mem_q [DEPTH][6];

    logic            push, xfer, pop;
    logic [BW-1:0]   head_word;

    // ready_q mirrors !full, so push never needs a separate full check.
    assign push      = in_valid && ready_q;
    assign xfer      = (state_q == StSend) && out_ready;
    assign pop       = xfer && (idx_q == LastIdx);
    assign head_word = mem_q[rd_ptr_q][idx_q];

    assign count_d = count_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        checksum_d  = checksum_q;
        frame_cnt_d = frame_cnt_q;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = head_word;
                out_last  = (idx_q == LastIdx);
                if (xfer) begin
                    checksum_d = checksum_q + head_word;
                    if (pop) begin
                        idx_d       = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // count_d already includes a push landing this cycle.
                        if (count_d == '0) begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            checksum_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            checksum_q  <= checksum_d;
            frame_cnt_q <= frame_cnt_d;
            ready_q     <= (count_d != CntW'(DEPTH));
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Frame storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q][0] <= s1;
            mem_q[wr_ptr_q][1] <= s2;
            mem_q[wr_ptr_q][2] <= s3;
            mem_q[wr_ptr_q][3] <= s4;
            mem_q[wr_ptr_q][4] <= s5;
            mem_q[wr_ptr_q][5] <= s6;
        end
    end

    assign in_ready  = ready_q;
    assign out_idx   = idx_q;
    assign checksum  = checksum_q;
    assign frame_cnt = frame_cnt_q;

endmodule
